stock_moving_avg: RTL
=====================

// Module: stock_moving_avg
// PURPOSE
//  Parametrised successor to the fixed average block. Keeps a sliding window of the last
//  2**WIN_LOG2 stock prices and outputs either their simple moving average (SMA) or an
//  exponential moving average (EMA). Both are computed continuously; the mode input picks one.
//  Sits between the price input interface and the downstream trading/compare logic.
// PARAMETERS
//  DATA_W     32  width of each price sample and of the average output (unsigned)
//  WIN_LOG2   3   log2 of the SMA window depth (window = 8 samples)
//  EMA_SHIFT  2   EMA smoothing: alpha = 2**-EMA_SHIFT
// PORTS
//  clk           in   1            system clock, rising edge
//  n_rst         in   1            reset; one clock, asynchronous, active-low
//  clear         in   1            synchronous flush of window, sums, EMA and count
//  stock_price   in   DATA_W       new price sample (unsigned)
//  data_ready    in   1            one-cycle strobe; stock_price is valid this cycle
//  mode          in   1            0 = SMA output, 1 = EMA output; may change at any time
//  average       out  DATA_W       selected average; holds its value between updates
//  avg_valid     out  1            one-cycle pulse; average was just updated and is valid
//  window_full   out  1            window holds 2**WIN_LOG2 samples since last reset/clear
//  sample_count  out  WIN_LOG2+1   samples held, saturates at 2**WIN_LOG2
// BEHAVIOUR
//  - Reset (n_rst=0, async): average=0, avg_valid=0, window_full=0, sample_count=0.
//    Running sum, EMA register, EMA-seeded flag and write pointer also go to 0. No buffer clear.
//    Reset mid-window drops all history.
//  - clear=1 at an edge: same end state as reset. clear beats data_ready in the same cycle;
//    that sample is dropped and there is no avg_valid.
//  - Sample accepted at edge N when data_ready=1 and clear=0.
//    average and avg_valid update at edge N+1, so latency is 1 cycle.
//    Back-to-back strobes on every cycle are supported.
//  - Window buffer: 2**WIN_LOG2 x DATA_W circular RAM, write pointer wraps modulo depth.
//    Oldest entry = entry at the write pointer.
//  - Running sum: DATA_W+WIN_LOG2 bits, so it never overflows.
//    While not full: sum += x.
//    When full: sum += x - oldest, and x overwrites oldest in the same cycle.
//  - sample_count increments per accepted sample, saturates at 2**WIN_LOG2.
//    window_full = (sample_count == 2**WIN_LOG2), registered.
//  - SMA value = sum >> WIN_LOG2 (floor), taken from the sum that includes the new sample.
//  - EMA: the first sample after reset/clear seeds ema = x.
//    After that: diff = signed {1'b0,x} - {1'b0,ema} (DATA_W+1 bits);
//    ema += diff >>> EMA_SHIFT (arithmetic shift, floor toward -inf). Result is always in range.
//  - Output select on an accepted sample:
//    mode=0: average <= SMA and avg_valid pulses only if the window is full after the sample.
//    mode=0 during warm-up: average holds, no pulse.
//    mode=1: average <= EMA and avg_valid pulses on every accepted sample.
//  - A mode change with no sample does not change average and does not pulse.
//    The next accepted sample uses the new mode. History of both averages is kept.
//  - avg_valid is never high for two cycles unless two samples arrive on consecutive cycles.
// TESTING  (DATA_W=32, WIN_LOG2=2, EMA_SHIFT=2)
//  1 Assert n_rst low mid-run, async (not on a clock edge) -> all outputs 0 at once; next window restarts from count 0.
//  2 mode=0, samples 10,20,30,40 -> no avg_valid for first 3; 4th: average=25, valid;
//    then 50 -> average=35.
//  3 mode=0, four samples 0xFFFFFFFF -> average=0xFFFFFFFF (no sum overflow);
//    then 0 -> average=0xBFFFFFFF.
//  4 mode=1, samples 100,200,0 -> average 100, 125, 93; avg_valid each cycle.
//  5 clear and data_ready in the same cycle with price 77 -> no pulse, average=0,
//    sample_count=0.
//  6 data_ready every cycle for 10 samples 1..10 while toggling mode every 3 samples
//    -> each output matches the golden model for its mode.
//    Pointer wrap is checked: last SMA = 8 (7+8+9+10=34, >>2 = 8).

Source files
------------

// File: rtl/stock_moving_avg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stock_moving_avg : sliding-window SMA and EMA of a price stream, muxed   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module stock_moving_avg #(
   parameter int DATA_W    = 32,
   parameter int WIN_LOG2  = 3,
   parameter int EMA_SHIFT = 2
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear,
   input  logic [DATA_W-1:0]   stock_price,
   input  logic                data_ready,
   input  logic                mode,
   output logic [DATA_W-1:0]   average,
   output logic                avg_valid,
   output logic                window_full,
   output logic [WIN_LOG2:0]   sample_count
);

   localparam int                DEPTH   = 1 << WIN_LOG2;
   localparam int                SUM_W   = DATA_W + WIN_LOG2;
   localparam logic [WIN_LOG2:0] C_DEPTH = (WIN_LOG2+1)'(DEPTH);

   logic [DATA_W-1:0]   window_mem [DEPTH];
   logic [WIN_LOG2-1:0] wr_ptr;
   logic [SUM_W-1:0]    sum;
   logic [DATA_W-1:0]   ema;
   logic                ema_seeded;

   logic                accept;
   logic [DATA_W-1:0]   oldest;
   logic [SUM_W-1:0]    sum_next;
   logic [WIN_LOG2:0]   count_next;
   logic                full_next;
   logic [DATA_W-1:0]   sma;
   logic signed [DATA_W:0] ema_diff;
   logic signed [DATA_W:0] ema_step;
   logic [DATA_W-1:0]   ema_next;

   assign accept = data_ready & ~clear;
   assign oldest = window_mem[wr_ptr];

   always_comb begin
      // Once full, the sample leaving the window is the one about to be overwritten.
      sum_next   = sum + {{WIN_LOG2{1'b0}}, stock_price}
                 - (window_full ? {{WIN_LOG2{1'b0}}, oldest} : {SUM_W{1'b0}});
      count_next = window_full ? sample_count : sample_count + 1'b1;
      full_next  = (count_next == C_DEPTH);
      sma        = sum_next[SUM_W-1:WIN_LOG2];
      ema_diff   = $signed({1'b0, stock_price}) - $signed({1'b0, ema});
      ema_step   = ema_diff >>> EMA_SHIFT;
      ema_next   = ema_seeded ? DATA_W'($signed({1'b0, ema}) + ema_step) : stock_price;
   end

   // Buffer contents are never cleared; only the pointer and count reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         window_mem[wr_ptr] <= stock_price;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr       <= '0;
         sum          <= '0;
         ema          <= '0;
         ema_seeded   <= 1'b0;
         sample_count <= '0;
         window_full  <= 1'b0;
         average      <= '0;
         avg_valid    <= 1'b0;
      end else if (clear) begin
         wr_ptr       <= '0;
         sum          <= '0;
         ema          <= '0;
         ema_seeded   <= 1'b0;
         sample_count <= '0;
         window_full  <= 1'b0;
         average      <= '0;
         avg_valid    <= 1'b0;
      end else if (accept) begin
         wr_ptr       <= wr_ptr + 1'b1;
         sum          <= sum_next;
         ema          <= ema_next;
         ema_seeded   <= 1'b1;
         sample_count <= count_next;
         window_full  <= full_next;
         if (mode) begin
            average   <= ema_next;
            avg_valid <= 1'b1;
         end else if (full_next) begin
            average   <= sma;
            avg_valid <= 1'b1;
         end else begin
            avg_valid <= 1'b0;
         end
      end else begin
         avg_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire
